// File: rtl/lc_arbiter.sv
// rtl/lc_arbiter.sv - round-robin L1D/L1I arbiter onto a single L2 port with fill routing
module lc_arbiter #(
    parameter int PADDR_BITS = 22,
    parameter int B          = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,

    input  logic                  l1d_valid_in,
    output logic                  l1d_ready_out,
    input  logic [PADDR_BITS-1:0] l1d_addr_in,
    input  logic [8*B-1:0]        l1d_value_in,
    input  logic                  l1d_we_in,

    input  logic                  l1i_valid_in,
    output logic                  l1i_ready_out,
    input  logic [PADDR_BITS-1:0] l1i_addr_in,

    output logic                  l1d_valid_out,
    input  logic                  l1d_ready_in,
    output logic [PADDR_BITS-1:0] l1d_addr_out,
    output logic [8*B-1:0]        l1d_value_out,

    output logic                  l1i_valid_out,
    input  logic                  l1i_ready_in,
    output logic [PADDR_BITS-1:0] l1i_addr_out,
    output logic [8*B-1:0]        l1i_value_out,

    output logic                  l2_valid_out,
    input  logic                  l2_ready_in,
    output logic [PADDR_BITS-1:0] l2_addr_out,
    output logic [8*B-1:0]        l2_value_out,
    output logic                  l2_we_out,

    input  logic                  l2_valid_in,
    output logic                  l2_ready_out,
    input  logic [PADDR_BITS-1:0] l2_addr_in,
    input  logic [8*B-1:0]        l2_value_in,

    output logic                  err_out
);

    localparam logic [PADDR_BITS-1:0] LINE_MASK = ~(PADDR_BITS'(B - 1));
    localparam logic GRANT_D = 1'b0;
    localparam logic GRANT_I = 1'b1;

    // run_q keeps every ready low while in reset and rises on the first edge after release
    logic                  run_q;

    logic                  buf_valid;
    logic [PADDR_BITS-1:0] buf_addr;
    logic [8*B-1:0]        buf_data;
    logic                  buf_we;
    logic                  last_grant;

    logic                  pend_d_valid;
    logic [PADDR_BITS-1:0] pend_d_addr;
    logic                  pend_i_valid;
    logic [PADDR_BITS-1:0] pend_i_addr;

    logic                  resp_d;
    logic                  resp_i;
    logic [PADDR_BITS-1:0] resp_addr;
    logic [8*B-1:0]        resp_data;
    logic                  err_q;

    logic [PADDR_BITS-1:0] d_line;
    logic [PADDR_BITS-1:0] i_line;
    logic [PADDR_BITS-1:0] fill_line;
    logic                  buf_free;
    logic                  elig_d;
    logic                  elig_i;
    logic                  grant_d;
    logic                  grant_i;
    logic                  fill_take;
    logic                  match_d;
    logic                  match_i;
    logic                  deliver_d;
    logic                  deliver_i;

    always_comb begin
        d_line    = l1d_addr_in & LINE_MASK;
        i_line    = l1i_addr_in & LINE_MASK;
        fill_line = l2_addr_in & LINE_MASK;

        buf_free = run_q && (!buf_valid || l2_ready_in);

        elig_i = l1i_valid_in && !pend_i_valid;
        if (l1d_we_in) begin
            // a writeback must not overtake an outstanding read of the same line
            elig_d = l1d_valid_in && !(pend_d_valid && pend_d_addr == d_line);
        end else begin
            elig_d = l1d_valid_in && !pend_d_valid;
        end

        grant_d = buf_free && elig_d && (!elig_i || last_grant == GRANT_I);
        grant_i = buf_free && elig_i && (!elig_d || last_grant == GRANT_D);

        fill_take = l2_valid_in && l2_ready_out;
        match_d   = pend_d_valid && pend_d_addr == fill_line;
        match_i   = pend_i_valid && pend_i_addr == fill_line;

        deliver_d = resp_d && l1d_ready_in;
        deliver_i = resp_i && l1i_ready_in;
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            run_q      <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_we     <= 1'b0;
            last_grant <= GRANT_I;
        end else begin
            run_q <= 1'b1;
            if (grant_d) begin
                buf_valid  <= 1'b1;
                buf_addr   <= d_line;
                buf_data   <= l1d_value_in;
                buf_we     <= l1d_we_in;
                last_grant <= GRANT_D;
            end else if (grant_i) begin
                buf_valid  <= 1'b1;
                buf_addr   <= i_line;
                buf_data   <= '0;
                buf_we     <= 1'b0;
                last_grant <= GRANT_I;
            end else if (buf_valid && l2_ready_in) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // A new read cannot be accepted while its requester is pending, so set and clear never collide.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            pend_d_valid <= 1'b0;
            pend_d_addr  <= '0;
            pend_i_valid <= 1'b0;
            pend_i_addr  <= '0;
        end else begin
            if (grant_d && !l1d_we_in) begin
                pend_d_valid <= 1'b1;
                pend_d_addr  <= d_line;
            end else if (deliver_d) begin
                pend_d_valid <= 1'b0;
            end
            if (grant_i) begin
                pend_i_valid <= 1'b1;
                pend_i_addr  <= i_line;
            end else if (deliver_i) begin
                pend_i_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            resp_d    <= 1'b0;
            resp_i    <= 1'b0;
            resp_addr <= '0;
            resp_data <= '0;
            err_q     <= 1'b0;
        end else if (fill_take) begin
            if (match_d || match_i) begin
                resp_d    <= match_d;
                resp_i    <= match_i;
                resp_addr <= fill_line;
                resp_data <= l2_value_in;
            end else begin
                err_q <= 1'b1;
            end
        end else begin
            if (deliver_d) begin
                resp_d <= 1'b0;
            end
            if (deliver_i) begin
                resp_i <= 1'b0;
            end
        end
    end

    always_comb begin
        l1d_ready_out = grant_d;
        l1i_ready_out = grant_i;

        l2_valid_out = buf_valid;
        l2_addr_out  = buf_addr;
        l2_value_out = buf_data;
        l2_we_out    = buf_we;

        l2_ready_out = run_q && !resp_d && !resp_i;

        l1d_valid_out = resp_d;
        l1d_addr_out  = resp_addr;
        l1d_value_out = resp_data;
        l1i_valid_out = resp_i;
        l1i_addr_out  = resp_addr;
        l1i_value_out = resp_data;

        err_out = err_q;
    end

endmodule

// File: tb/tb_lc_arbiter.sv
// tb/tb_lc_arbiter.sv - directed self-checking bench for lc_arbiter
module tb_lc_arbiter;

    localparam int P  = 22;
    localparam int DW = 512;

    logic          clk_in;
    logic          rst_N_in;
    logic          l1d_valid_in, l1d_ready_out, l1d_we_in;
    logic [P-1:0]  l1d_addr_in;
    logic [DW-1:0] l1d_value_in;
    logic          l1i_valid_in, l1i_ready_out;
    logic [P-1:0]  l1i_addr_in;
    logic          l1d_valid_out, l1d_ready_in;
    logic [P-1:0]  l1d_addr_out;
    logic [DW-1:0] l1d_value_out;
    logic          l1i_valid_out, l1i_ready_in;
    logic [P-1:0]  l1i_addr_out;
    logic [DW-1:0] l1i_value_out;
    logic          l2_valid_out, l2_ready_in, l2_we_out;
    logic [P-1:0]  l2_addr_out;
    logic [DW-1:0] l2_value_out;
    logic          l2_valid_in, l2_ready_out;
    logic [P-1:0]  l2_addr_in;
    logic [DW-1:0] l2_value_in;
    logic          err_out;

    int total = 0;
    int bad   = 0;

    lc_arbiter #(.PADDR_BITS(P), .B(64)) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .l1d_valid_in(l1d_valid_in), .l1d_ready_out(l1d_ready_out),
        .l1d_addr_in(l1d_addr_in), .l1d_value_in(l1d_value_in), .l1d_we_in(l1d_we_in),
        .l1i_valid_in(l1i_valid_in), .l1i_ready_out(l1i_ready_out), .l1i_addr_in(l1i_addr_in),
        .l1d_valid_out(l1d_valid_out), .l1d_ready_in(l1d_ready_in),
        .l1d_addr_out(l1d_addr_out), .l1d_value_out(l1d_value_out),
        .l1i_valid_out(l1i_valid_out), .l1i_ready_in(l1i_ready_in),
        .l1i_addr_out(l1i_addr_out), .l1i_value_out(l1i_value_out),
        .l2_valid_out(l2_valid_out), .l2_ready_in(l2_ready_in),
        .l2_addr_out(l2_addr_out), .l2_value_out(l2_value_out), .l2_we_out(l2_we_out),
        .l2_valid_in(l2_valid_in), .l2_ready_out(l2_ready_out),
        .l2_addr_in(l2_addr_in), .l2_value_in(l2_value_in),
        .err_out(err_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_N_in = 1'b0;
        #3;
        rst_N_in = 1'b1;
        cyc();
    endtask

    task automatic fill(input logic [P-1:0] addr, input logic [63:0] val);
        int n;
        n = 0;
        l2_valid_in = 1'b1;
        l2_addr_in  = addr;
        l2_value_in = '0;
        l2_value_in[63:0] = val;
        #1;
        while (!l2_ready_out && n < 10) begin
            cyc();
            #1;
            n++;
        end
        chk("fill_timeout", 64'(n >= 10), 64'd0);
        cyc();
        l2_valid_in = 1'b0;
        #1;
    endtask

    initial begin
        rst_N_in     = 1'b0;
        l1d_valid_in = 1'b0; l1d_we_in = 1'b0; l1d_addr_in = '0; l1d_value_in = '0;
        l1i_valid_in = 1'b0; l1i_addr_in = '0;
        l1d_ready_in = 1'b1; l1i_ready_in = 1'b1;
        l2_ready_in  = 1'b1; l2_valid_in = 1'b0; l2_addr_in = '0; l2_value_in = '0;

        // reset state
        cyc(); cyc();
        chk("rst_l2_valid", 64'(l2_valid_out), 64'd0);
        chk("rst_l2_ready", 64'(l2_ready_out), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_d_valid", 64'(l1d_valid_out), 64'd0);
        rst_N_in = 1'b1;
        cyc();
        chk("post_rst_l2_ready", 64'(l2_ready_out), 64'd1);

        // lone L1D read 0x2010
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h2010; l1d_we_in = 1'b0;
        #1;
        chk("t1_d_ready", 64'(l1d_ready_out), 64'd1);
        chk("t1_i_ready", 64'(l1i_ready_out), 64'd0);
        cyc();
        l1d_valid_in = 1'b0;
        #1;
        chk("t1_l2_valid", 64'(l2_valid_out), 64'd1);
        chk("t1_l2_addr", 64'(l2_addr_out), 64'h2000);
        chk("t1_l2_we", 64'(l2_we_out), 64'd0);
        cyc();
        chk("t1_l2_drained", 64'(l2_valid_out), 64'd0);
        fill(22'h2000, 64'hDEADBEEF);
        chk("t1_fill_d_valid", 64'(l1d_valid_out), 64'd1);
        chk("t1_fill_d_value", l1d_value_out[63:0], 64'hDEADBEEF);
        chk("t1_fill_d_addr", 64'(l1d_addr_out), 64'h2000);
        chk("t1_fill_i_valid", 64'(l1i_valid_out), 64'd0);
        chk("t1_l2_ready_busy", 64'(l2_ready_out), 64'd0);
        cyc();
        chk("t1_delivered", 64'(l1d_valid_out), 64'd0);
        chk("t1_l2_ready_free", 64'(l2_ready_out), 64'd1);

        // simultaneous reads: D wins the first tie after reset
        do_reset();
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h1000; l1d_we_in = 1'b0;
        l1i_valid_in = 1'b1; l1i_addr_in = 22'h3000;
        #1;
        chk("t2_d_first", 64'(l1d_ready_out), 64'd1);
        chk("t2_i_wait", 64'(l1i_ready_out), 64'd0);
        cyc();
        l1d_valid_in = 1'b0;
        #1;
        chk("t2_i_next", 64'(l1i_ready_out), 64'd1);
        chk("t2_l2_addr_d", 64'(l2_addr_out), 64'h1000);
        cyc();
        l1i_valid_in = 1'b0;
        #1;
        chk("t2_l2_addr_i", 64'(l2_addr_out), 64'h3000);
        fill(22'h1000, 64'h11);
        cyc();
        fill(22'h3000, 64'h33);
        chk("t2_fill_i", 64'(l1i_valid_out), 64'd1);
        chk("t2_fill_i_value", l1i_value_out[63:0], 64'h33);
        cyc();

        // lone D write leaves last_grant = D, so the next tie goes to I
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h8000; l1d_we_in = 1'b1;
        l1d_value_in = '0; l1d_value_in[63:0] = 64'hCAFE;
        #1;
        chk("t2_wr_ready", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_valid_in = 1'b0;
        #1;
        chk("t2_wr_we", 64'(l2_we_out), 64'd1);
        chk("t2_wr_value", l2_value_out[63:0], 64'hCAFE);
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h1100; l1d_we_in = 1'b0;
        l1i_valid_in = 1'b1; l1i_addr_in = 22'h3100;
        #1;
        chk("t2b_i_first", 64'(l1i_ready_out), 64'd1);
        chk("t2b_d_wait", 64'(l1d_ready_out), 64'd0);
        cyc();
        l1i_valid_in = 1'b0;
        #1;
        chk("t2b_d_next", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_valid_in = 1'b0;
        fill(22'h1100, 64'h1);
        cyc();
        fill(22'h3100, 64'h3);
        cyc();

        // shared fill 0x4000 to both requesters
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h4000; l1d_we_in = 1'b0;
        l1i_valid_in = 1'b1; l1i_addr_in = 22'h4000;
        #1;
        chk("t3_i_first", 64'(l1i_ready_out), 64'd1);
        cyc();
        l1i_valid_in = 1'b0;
        #1;
        chk("t3_d_next", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_valid_in = 1'b0;
        l1i_ready_in = 1'b0;
        fill(22'h4000, 64'h4444);
        chk("t3_both_d", 64'(l1d_valid_out), 64'd1);
        chk("t3_both_i", 64'(l1i_valid_out), 64'd1);
        chk("t3_both_i_value", l1i_value_out[63:0], 64'h4444);
        cyc();
        chk("t3_d_done", 64'(l1d_valid_out), 64'd0);
        chk("t3_i_hold", 64'(l1i_valid_out), 64'd1);
        chk("t3_l2_busy1", 64'(l2_ready_out), 64'd0);
        cyc();
        chk("t3_l2_busy2", 64'(l2_ready_out), 64'd0);
        l1i_ready_in = 1'b1;
        cyc();
        chk("t3_i_done", 64'(l1i_valid_out), 64'd0);
        chk("t3_l2_free", 64'(l2_ready_out), 64'd1);

        // write to a line with a pending read is held back
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h5000; l1d_we_in = 1'b0;
        #1;
        chk("t4_rd_ready", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_we_in = 1'b1;
        #1;
        chk("t4_wr_block0", 64'(l1d_ready_out), 64'd0);
        cyc();
        chk("t4_wr_block1", 64'(l1d_ready_out), 64'd0);
        l1d_addr_in = 22'h6000;
        #1;
        chk("t4_wr_other", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_addr_in = 22'h5000;
        #1;
        chk("t4_wr_other_addr", 64'(l2_addr_out), 64'h6000);
        chk("t4_wr_block2", 64'(l1d_ready_out), 64'd0);
        fill(22'h5000, 64'h55);
        chk("t4_fill_valid", 64'(l1d_valid_out), 64'd1);
        chk("t4_wr_block3", 64'(l1d_ready_out), 64'd0);
        cyc();
        chk("t4_wr_release", 64'(l1d_ready_out), 64'd1);
        cyc();
        l1d_valid_in = 1'b0; l1d_we_in = 1'b0;
        cyc();

        // unmatched fill is dropped
        fill(22'h7000, 64'h77);
        chk("t5_err", 64'(err_out), 64'd1);
        chk("t5_no_d", 64'(l1d_valid_out), 64'd0);
        chk("t5_no_i", 64'(l1i_valid_out), 64'd0);
        chk("t5_l2_ready", 64'(l2_ready_out), 64'd1);
        cyc(); cyc();
        chk("t5_err_sticky", 64'(err_out), 64'd1);

        // L2 stall with both requesters valid, then reset mid-stall
        l2_ready_in  = 1'b0;
        l1d_valid_in = 1'b1; l1d_addr_in = 22'h9000; l1d_we_in = 1'b1;
        l1i_valid_in = 1'b1; l1i_addr_in = 22'hA000;
        #1;
        chk("t6_i_grant", 64'(l1i_ready_out), 64'd1);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("t6_hold_valid", 64'(l2_valid_out), 64'd1);
            chk("t6_hold_addr", 64'(l2_addr_out), 64'hA000);
            chk("t6_hold_we", 64'(l2_we_out), 64'd0);
            chk("t6_d_ready", 64'(l1d_ready_out), 64'd0);
            chk("t6_i_ready", 64'(l1i_ready_out), 64'd0);
            cyc();
        end
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("t6_rst_l2_valid", 64'(l2_valid_out), 64'd0);
        chk("t6_rst_l2_addr", 64'(l2_addr_out), 64'd0);
        chk("t6_rst_d_ready", 64'(l1d_ready_out), 64'd0);
        chk("t6_rst_i_ready", 64'(l1i_ready_out), 64'd0);
        chk("t6_rst_l2_ready", 64'(l2_ready_out), 64'd0);
        chk("t6_rst_err", 64'(err_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
